mem_port_arbiter: RTL and testbench

- Shares one unified single-port memory between the instruction-fetch requester (IF) and the data-memory requester (DM, loads/stores).
- Sits between the fetch/MEM stages and the memory model, and replaces the separate instruction and data caches with one port.
- Keeps one transaction outstanding at a time. Memory latency is fixed.
- DM has priority over IF; a starvation counter bounds how long IF can be locked out.

---
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch (IF) and data memory (DM).
// One access in flight at a time, fixed latency, DM priority with bounded IF starvation.
module mem_port_arbiter #(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 64,
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          if_req_i,
   input  logic [AW-1:0] if_addr_i,
   output logic          if_gnt_o,
   output logic          if_rvalid_o,
   output logic [DW-1:0] if_rdata_o,
   input  logic          dm_req_i,
   input  logic          dm_we_i,
   input  logic [AW-1:0] dm_addr_i,
   input  logic [DW-1:0] dm_wdata_i,
   output logic          dm_gnt_o,
   output logic          dm_rvalid_o,
   output logic [DW-1:0] dm_rdata_o,
   output logic          mem_req_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic [DW-1:0] mem_rdata_i,
   output logic          busy_o
);

   localparam int unsigned   LW         = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int unsigned   SW         = $clog2(STARVE_MAX + 1);
   localparam logic [LW-1:0] LAT_LAST   = LW'(MEM_LAT - 1);
   localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

   typedef enum logic {IDLE, WAIT} state_t;
   typedef enum logic {OWN_IF, OWN_DM} owner_t;

   state_t        state_q, state_d;
   owner_t        owner_q;
   logic          we_q;
   logic [LW-1:0] lat_q;
   logic [SW-1:0] starve_q;
   logic          take_if, take_dm, done;

   // IF only beats a competing DM request once it has lost STARVE_MAX times in a row
   always_comb begin
      take_if = 1'b0;
      take_dm = 1'b0;
      if (state_q == IDLE && !rst_i) begin
         if (dm_req_i && !(if_req_i && starve_q == STARVE_TOP)) begin
            take_dm = 1'b1;
         end else if (if_req_i) begin
            take_if = 1'b1;
         end
      end
   end

   assign done = (state_q == WAIT) && (lat_q == LAT_LAST);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (take_if || take_dm) state_d = WAIT;
         WAIT:    if (done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         owner_q  <= OWN_IF;
         we_q     <= 1'b0;
         lat_q    <= '0;
         starve_q <= '0;
      end else begin
         if (take_if || take_dm) begin
            owner_q <= take_dm ? OWN_DM : OWN_IF;
            we_q    <= take_dm & dm_we_i;
            lat_q   <= '0;
         end else if (state_q == WAIT) begin
            lat_q <= lat_q + 1'b1;
         end
         if (take_if) begin
            starve_q <= '0;
         end else if (take_dm && if_req_i && starve_q != STARVE_TOP) begin
            starve_q <= starve_q + 1'b1;
         end
      end
   end

   always_comb begin
      if_gnt_o    = take_if;
      dm_gnt_o    = take_dm;
      mem_req_o   = take_if | take_dm;
      mem_we_o    = take_dm & dm_we_i;
      mem_addr_o  = take_dm ? dm_addr_i : (take_if ? if_addr_i : '0);
      mem_wdata_o = take_dm ? dm_wdata_i : '0;
      busy_o      = !rst_i && state_q == WAIT;
      if_rvalid_o = !rst_i && done && owner_q == OWN_IF;
      dm_rvalid_o = !rst_i && done && owner_q == OWN_DM;
      if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
      dm_rdata_o  = (dm_rvalid_o && !we_q) ? mem_rdata_i : '0;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, starvation and reset sequences,
// then random traffic checked against a transaction-level model with its own memory image.
module tb_mem_port_arbiter;

   localparam int unsigned ML = 2;
   localparam int unsigned SM = 4;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_gnt_o, if_rvalid_o;
   logic [63:0] if_rdata_o;
   logic        dm_req_i, dm_we_i;
   logic [31:0] dm_addr_i;
   logic [63:0] dm_wdata_i;
   logic        dm_gnt_o, dm_rvalid_o;
   logic [63:0] dm_rdata_o;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o;
   logic [63:0] mem_wdata_o;
   logic [63:0] mem_rdata_i;
   logic        busy_o;

   mem_port_arbiter #(.AW(32), .DW(64), .MEM_LAT(ML), .STARVE_MAX(SM)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
      .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        if_gnt, dm_gnt, if_rv, dm_rv, busy, mem_req, mem_we;
      logic [31:0] mem_addr;
      logic [63:0] mem_wdata, if_rdata, dm_rdata;
   } obs_t;

   typedef struct {
      logic        if_req;
      logic [31:0] if_addr;
      logic        dm_req, dm_we;
      logic [31:0] dm_addr;
      logic [63:0] dm_wdata;
      obs_t        exp;
   } vec_t;

   typedef struct {
      int          due;
      logic [63:0] data;
   } rsp_t;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   rsp_t        rsp_q[$];
   logic [63:0] phys_mem[logic [31:0]];
   logic [63:0] ref_mem[logic [31:0]];

   bit          m_pend = 1'b0;
   int          m_due  = 0;
   bit          m_dm   = 1'b0;
   bit          m_we   = 1'b0;
   logic [63:0] m_data = '0;
   int unsigned m_starve = 0;

   obs_t snap;
   logic if_gnt_last = 1'b0;
   logic dm_gnt_last = 1'b0;

   function automatic logic [63:0] dflt(input logic [31:0] a);
      return {32'h0, a} + 64'd3;
   endfunction

   function automatic logic [63:0] rd_phys(input logic [31:0] a);
      return phys_mem.exists(a) ? phys_mem[a] : dflt(a);
   endfunction

   function automatic logic [63:0] rd_ref(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0b required=%0b", nm, cyc, act, exp);
      end
   endtask

   // Transaction-level reference: a grant opens an access due ML cycles later.
   task automatic ref_step();
      obs_t e;
      bit   dm_win, if_win;
      e = '{default: '0};
      if (rst_i) begin
         m_pend   = 1'b0;
         m_starve = 0;
      end else if (m_pend && cyc == m_due) begin
         e.busy = 1'b1;
         if (m_dm) begin
            e.dm_rv    = 1'b1;
            e.dm_rdata = m_we ? 64'h0 : m_data;
         end else begin
            e.if_rv    = 1'b1;
            e.if_rdata = m_data;
         end
         m_pend = 1'b0;
      end else if (m_pend) begin
         e.busy = 1'b1;
      end else begin
         dm_win = dm_req_i && !(if_req_i && m_starve == SM);
         if_win = !dm_win && if_req_i;
         if (dm_win) begin
            if (if_req_i && m_starve < SM) m_starve++;
            e.dm_gnt   = 1'b1;
            e.mem_req  = 1'b1;
            e.mem_we   = dm_we_i;
            e.mem_addr = dm_addr_i;
            e.mem_wdata = dm_wdata_i;
            m_dm   = 1'b1;
            m_we   = dm_we_i;
            m_data = rd_ref(dm_addr_i);
            if (dm_we_i) ref_mem[dm_addr_i] = dm_wdata_i;
         end else if (if_win) begin
            m_starve   = 0;
            e.if_gnt   = 1'b1;
            e.mem_req  = 1'b1;
            e.mem_addr = if_addr_i;
            m_dm   = 1'b0;
            m_we   = 1'b0;
            m_data = rd_ref(if_addr_i);
         end
         if (dm_win || if_win) begin
            m_pend = 1'b1;
            m_due  = cyc + int'(ML);
         end
      end
      chk1("ref_if_gnt", snap.if_gnt, e.if_gnt);
      chk1("ref_dm_gnt", snap.dm_gnt, e.dm_gnt);
      chk1("ref_if_rvalid", snap.if_rv, e.if_rv);
      chk1("ref_dm_rvalid", snap.dm_rv, e.dm_rv);
      chk1("ref_busy", snap.busy, e.busy);
      chk1("ref_mem_req", snap.mem_req, e.mem_req);
      chk1("ref_mem_we", snap.mem_we, e.mem_we);
      chk("ref_mem_addr", 64'(snap.mem_addr), 64'(e.mem_addr));
      if (e.mem_we) chk("ref_mem_wdata", snap.mem_wdata, e.mem_wdata);
      chk("ref_if_rdata", snap.if_rdata, e.if_rdata);
      chk("ref_dm_rdata", snap.dm_rdata, e.dm_rdata);
   endtask

   // One clock cycle: sample and check at negedge, then advance the memory's return path.
   task automatic tick();
      rsp_t r;
      @(negedge clk);
      snap.if_gnt    = if_gnt_o;
      snap.dm_gnt    = dm_gnt_o;
      snap.if_rv     = if_rvalid_o;
      snap.dm_rv     = dm_rvalid_o;
      snap.busy      = busy_o;
      snap.mem_req   = mem_req_o;
      snap.mem_we    = mem_we_o;
      snap.mem_addr  = mem_addr_o;
      snap.mem_wdata = mem_wdata_o;
      snap.if_rdata  = if_rdata_o;
      snap.dm_rdata  = dm_rdata_o;
      if (mem_req_o) begin
         if (mem_we_o) phys_mem[mem_addr_o] = mem_wdata_o;
         else rsp_q.push_back('{cyc + int'(ML), rd_phys(mem_addr_o)});
      end
      ref_step();
      if_gnt_last = if_gnt_o;
      dm_gnt_last = dm_gnt_o;
      @(posedge clk);
      cyc++;
      #1;
      while (rsp_q.size() > 0 && rsp_q[0].due < cyc) void'(rsp_q.pop_front());
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
         r = rsp_q.pop_front();
         mem_rdata_i = r.data;
      end else begin
         mem_rdata_i = {$urandom, $urandom};
      end
   endtask

   function automatic vec_t v(input logic ir, input logic [31:0] ia, input logic dr,
                              input logic dw, input logic [31:0] da, input logic [63:0] dwd,
                              input logic eig, input logic edg, input logic eir, input logic edr,
                              input logic eb, input logic [31:0] ema, input logic [63:0] erd);
      vec_t r;
      r.if_req  = ir;  r.if_addr = ia;
      r.dm_req  = dr;  r.dm_we   = dw;
      r.dm_addr = da;  r.dm_wdata = dwd;
      r.exp.if_gnt    = eig;
      r.exp.dm_gnt    = edg;
      r.exp.if_rv     = eir;
      r.exp.dm_rv     = edr;
      r.exp.busy      = eb;
      r.exp.mem_req   = eig | edg;
      r.exp.mem_we    = edg & dw;
      r.exp.mem_addr  = ema;
      r.exp.mem_wdata = (edg & dw) ? dwd : 64'h0;
      r.exp.if_rdata  = eir ? erd : 64'h0;
      r.exp.dm_rdata  = edr ? erd : 64'h0;
      return r;
   endfunction

   initial begin
      vec_t tbl[18];
      bit   got[6];
      bit   exp4[6];
      int   n;

      //            ir  ia     dr dw da     dwd              ig dg ir dr bsy addr   rdata
      tbl[0]  = v(1, 32'h10, 0, 0, 32'h0,  64'h0,           1, 0, 0, 0, 0, 32'h10, 64'h0);
      tbl[1]  = v(0, 32'h0,  0, 0, 32'h0,  64'h0,           0, 0, 0, 0, 1, 32'h0,  64'h0);
      tbl[2]  = v(0, 32'h0,  0, 0, 32'h0,  64'h0,           0, 0, 1, 0, 1, 32'h0,  64'h13);
      tbl[3]  = v(0, 32'h0,  1, 1, 32'h20, 64'hDEADBEEF,    0, 1, 0, 0, 0, 32'h20, 64'h0);
      tbl[4]  = v(0, 32'h0,  0, 0, 32'h0,  64'h0,           0, 0, 0, 0, 1, 32'h0,  64'h0);
      tbl[5]  = v(0, 32'h0,  0, 0, 32'h0,  64'h0,           0, 0, 0, 1, 1, 32'h0,  64'h0);
      tbl[6]  = v(1, 32'h40, 1, 0, 32'h20, 64'h0,           0, 1, 0, 0, 0, 32'h20, 64'h0);
      tbl[7]  = v(1, 32'h40, 0, 0, 32'h0,  64'h0,           0, 0, 0, 0, 1, 32'h0,  64'h0);
      tbl[8]  = v(1, 32'h40, 0, 0, 32'h0,  64'h0,           0, 0, 0, 1, 1, 32'h0,  64'hDEADBEEF);
      tbl[9]  = v(1, 32'h40, 0, 0, 32'h0,  64'h0,           1, 0, 0, 0, 0, 32'h40, 64'h0);
      tbl[10] = v(0, 32'h0,  0, 0, 32'h0,  64'h0,           0, 0, 0, 0, 1, 32'h0,  64'h0);
      tbl[11] = v(0, 32'h0,  0, 0, 32'h0,  64'h0,           0, 0, 1, 0, 1, 32'h0,  64'h43);
      tbl[12] = v(0, 32'h0,  1, 0, 32'h30, 64'h0,           0, 1, 0, 0, 0, 32'h30, 64'h0);
      tbl[13] = v(1, 32'h50, 0, 0, 32'h0,  64'h0,           0, 0, 0, 0, 1, 32'h0,  64'h0);
      tbl[14] = v(1, 32'h50, 0, 0, 32'h0,  64'h0,           0, 0, 0, 1, 1, 32'h0,  64'h33);
      tbl[15] = v(1, 32'h50, 0, 0, 32'h0,  64'h0,           1, 0, 0, 0, 0, 32'h50, 64'h0);
      tbl[16] = v(0, 32'h0,  0, 0, 32'h0,  64'h0,           0, 0, 0, 0, 1, 32'h0,  64'h0);
      tbl[17] = v(0, 32'h0,  0, 0, 32'h0,  64'h0,           0, 0, 1, 0, 1, 32'h0,  64'h53);

      rst_i = 1'b1; if_req_i = 1'b1; if_addr_i = 32'h8;
      dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'hC; dm_wdata_i = 64'h1234;
      mem_rdata_i = '0;
      repeat (3) tick();
      rst_i = 1'b0; if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0;

      for (int unsigned i = 0; i < 18; i++) begin
         if_req_i = tbl[i].if_req;  if_addr_i = tbl[i].if_addr;
         dm_req_i = tbl[i].dm_req;  dm_we_i   = tbl[i].dm_we;
         dm_addr_i = tbl[i].dm_addr; dm_wdata_i = tbl[i].dm_wdata;
         tick();
         chk1("tbl_if_gnt", snap.if_gnt, tbl[i].exp.if_gnt);
         chk1("tbl_dm_gnt", snap.dm_gnt, tbl[i].exp.dm_gnt);
         chk1("tbl_if_rvalid", snap.if_rv, tbl[i].exp.if_rv);
         chk1("tbl_dm_rvalid", snap.dm_rv, tbl[i].exp.dm_rv);
         chk1("tbl_busy", snap.busy, tbl[i].exp.busy);
         chk1("tbl_mem_req", snap.mem_req, tbl[i].exp.mem_req);
         chk1("tbl_mem_we", snap.mem_we, tbl[i].exp.mem_we);
         chk("tbl_mem_addr", 64'(snap.mem_addr), 64'(tbl[i].exp.mem_addr));
         if (tbl[i].exp.mem_we) chk("tbl_mem_wdata", snap.mem_wdata, tbl[i].exp.mem_wdata);
         chk("tbl_if_rdata", snap.if_rdata, tbl[i].exp.if_rdata);
         chk("tbl_dm_rdata", snap.dm_rdata, tbl[i].exp.dm_rdata);
      end

      // Starvation: both sides request back to back; grant order must be D D D D I D.
      exp4 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      n = 0;
      if_req_i = 1'b1; if_addr_i = 32'h60;
      dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h100;
      for (int i = 0; i < 30 && n < 6; i++) begin
         tick();
         if (snap.dm_gnt) begin
            got[n] = 1'b1; n++;
            dm_addr_i = dm_addr_i + 32'h8;
         end else if (snap.if_gnt) begin
            got[n] = 1'b0; n++;
         end
      end
      chk("starve_grant_count", 64'(n), 64'd6);
      for (int k = 0; k < n; k++) chk1($sformatf("starve_grant_%0d_is_dm", k), got[k], exp4[k]);
      if_req_i = 1'b0; dm_req_i = 1'b0;
      repeat (4) tick();

      // Reset in the middle of a DM read: the access is dropped silently.
      dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h20;
      tick();
      chk1("rst_seq_dm_gnt", snap.dm_gnt, 1'b1);
      dm_req_i = 1'b0; rst_i = 1'b1;
      tick();
      chk1("rst_seq_busy_in_rst", snap.busy, 1'b0);
      chk1("rst_seq_mem_req_in_rst", snap.mem_req, 1'b0);
      chk1("rst_seq_dm_rvalid_in_rst", snap.dm_rv, 1'b0);
      rst_i = 1'b0;
      tick();
      chk1("rst_seq_no_dm_rvalid", snap.dm_rv, 1'b0);
      chk("rst_seq_dm_rdata", snap.dm_rdata, 64'h0);
      chk1("rst_seq_busy_after", snap.busy, 1'b0);
      if_req_i = 1'b1; if_addr_i = 32'h70;
      tick();
      chk1("rst_seq_if_gnt_first_cycle", snap.if_gnt, 1'b1);
      chk("rst_seq_if_addr", 64'(snap.mem_addr), 64'h70);
      if_req_i = 1'b0;
      repeat (3) tick();

      // Random traffic obeying the hold-until-grant protocol, with occasional drops and resets.
      for (int i = 0; i < 3000; i++) begin
         rst_i = ($urandom_range(0, 199) == 0);
         if (if_req_i && !if_gnt_last) begin
            if ($urandom_range(0, 15) == 0) if_req_i = 1'b0;
         end else begin
            if_req_i  = ($urandom_range(0, 2) != 0);
            if_addr_i = 32'($urandom_range(0, 15)) << 3;
         end
         if (dm_req_i && !dm_gnt_last) begin
            if ($urandom_range(0, 15) == 0) dm_req_i = 1'b0;
         end else begin
            dm_req_i   = ($urandom_range(0, 1) != 0);
            dm_we_i    = ($urandom_range(0, 1) != 0);
            dm_addr_i  = 32'($urandom_range(0, 15)) << 3;
            dm_wdata_i = {$urandom, $urandom};
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
